bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 104 ++++++++++
 tb/tb_bcd_countdown_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - two-digit BCD countdown timer; optional low-time warning via TIMER_WARN_EN
module bcd_countdown_timer #(
    parameter logic [3:0] PRESET_TENS = 4'd6,
    parameter logic [3:0] PRESET_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec_in,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       time_up,
    output logic       expire_pulse,
    output logic       warn
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSED  = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    logic [1:0] state, state_nxt;
    logic [3:0] tens_nxt, ones_nxt;
    logic       pulse_nxt;
    logic       value_zero;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign value_zero = (tens == 4'd0) && (ones == 4'd0);

    always_comb begin
        state_nxt = state;
        tens_nxt  = tens;
        ones_nxt  = ones;
        pulse_nxt = 1'b0;
        if (load) begin
            tens_nxt  = clamp9(load_value[7:4]);
            ones_nxt  = clamp9(load_value[3:0]);
            state_nxt = IDLE;
        end else if (pause) begin
            if (state == RUN)
                state_nxt = PAUSED;
        end else if (start) begin
            if (state == IDLE || state == PAUSED) begin
                if (value_zero) begin
                    state_nxt = EXPIRED;
                    pulse_nxt = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
        end else if (one_sec_in && state == RUN) begin
            // A zero value in RUN is unreachable; treat it as expiry rather than wrapping.
            if (value_zero || (tens == 4'd0 && ones == 4'd1)) begin
                tens_nxt  = 4'd0;
                ones_nxt  = 4'd0;
                state_nxt = EXPIRED;
                pulse_nxt = 1'b1;
            end else if (ones != 4'd0) begin
                ones_nxt = ones - 4'd1;
            end else begin
                ones_nxt = 4'd9;
                tens_nxt = tens - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tens         <= PRESET_TENS;
            ones         <= PRESET_ONES;
            running      <= 1'b0;
            time_up      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            tens         <= tens_nxt;
            ones         <= ones_nxt;
            running      <= (state_nxt == RUN);
            time_up      <= (state_nxt == EXPIRED);
            expire_pulse <= pulse_nxt;
        end
    end

`ifdef TIMER_WARN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            warn <= 1'b0;
        else
            warn <= (state_nxt == RUN || state_nxt == PAUSED) &&
                    (tens_nxt == 4'd0) && (ones_nxt != 4'd0);
    end
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - randomized and directed bench against an integer-valued timer model
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_sec_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic [3:0] tens, ones;
    logic       running, time_up, expire_pulse, warn;

    int n_checks = 0;
    int n_fail = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;
    int m_val = 60;
    int m_mode = M_IDLE;
    bit m_pulse = 1'b0;

    bcd_countdown_timer dut (
        .clk(clk), .reset(reset), .one_sec_in(one_sec_in), .start(start),
        .pause(pause), .load(load), .load_value(load_value), .tens(tens),
        .ones(ones), .running(running), .time_up(time_up),
        .expire_pulse(expire_pulse), .warn(warn)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {tens, ones, running, time_up, expire_pulse, warn};

    function automatic int clamp_digit(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic void model_reset();
        m_val = 60; m_mode = M_IDLE; m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input bit ld, input logic [7:0] lv, input bit st,
                                       input bit pa, input bit tk);
        m_pulse = 1'b0;
        if (ld) begin
            m_val  = clamp_digit(int'(lv[7:4])) * 10 + clamp_digit(int'(lv[3:0]));
            m_mode = M_IDLE;
        end else if (pa) begin
            if (m_mode == M_RUN) m_mode = M_PAUSED;
        end else if (st) begin
            if (m_mode == M_IDLE || m_mode == M_PAUSED) begin
                if (m_val == 0) begin m_mode = M_EXPIRED; m_pulse = 1'b1; end
                else m_mode = M_RUN;
            end
        end else if (tk && m_mode == M_RUN) begin
            m_val = m_val - 1;
            if (m_val == 0) begin m_mode = M_EXPIRED; m_pulse = 1'b1; end
        end
    endfunction

    function automatic bit model_warn();
`ifdef TIMER_WARN_EN
        return (m_mode == M_RUN || m_mode == M_PAUSED) && m_val >= 1 && m_val <= 9;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] expected();
        logic [3:0] t, o;
        t = 4'(m_val / 10);
        o = 4'(m_val % 10);
        return {t, o, m_mode == M_RUN, m_mode == M_EXPIRED, m_pulse, model_warn()};
    endfunction

    task automatic step(input bit ld, input logic [7:0] lv, input bit st, input bit pa, input bit tk);
        load = ld; load_value = lv; start = st; pause = pa; one_sec_in = tk;
        @(posedge clk);
        model_step(ld, lv, st, pa, tk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; one_sec_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs !== {4'd6, 4'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", obs, {4'd6, 4'd0, 4'b0000});
        end
        reset = 1'b0;
    endtask

    task automatic test_countdown();
        logic [7:0] want [4] = '{8'h60, 8'h59, 8'h58, 8'h57};
        step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0, 8'h00, 0, 0, 1);
            n_checks++;
            if ({tens, ones, running} !== {want[i], 1'b1} || obs !== expected()) begin
                n_fail++;
                $display("FAIL countdown[%0d]: got %h required %h (digits %h)", i, obs, expected(), want[i]);
            end
        end
    endtask

    task automatic test_expire();
        step(1, 8'h02, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({tens, ones} !== 8'h01 || obs !== expected()) begin
            n_fail++;
            $display("FAIL expire_01: got %h required %h", obs, expected());
        end
        step(0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({tens, ones, running, time_up, expire_pulse} !== {8'h00, 3'b011} || obs !== expected()) begin
            n_fail++;
            $display("FAIL expire_00: got %h required %h", obs, expected());
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, i == 2, 0, 1);
            n_checks++;
            if ({tens, ones, running, time_up, expire_pulse} !== {8'h00, 3'b010} || obs !== expected()) begin
                n_fail++;
                $display("FAIL expire_hold[%0d]: got %h required %h", i, obs, expected());
            end
        end
    endtask

    task automatic test_pause();
        step(1, 8'h35, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 1);
        n_checks++;
        if ({tens, ones, running, time_up} !== {8'h35, 2'b00} || obs !== expected()) begin
            n_fail++;
            $display("FAIL pause_with_tick: got %h required %h", obs, expected());
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 0, 0, 1);
            n_checks++;
            if ({tens, ones} !== 8'h35 || obs !== expected()) begin
                n_fail++;
                $display("FAIL paused_tick[%0d]: got %h required %h", i, obs, expected());
            end
        end
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        n_checks++;
        if ({tens, ones, running} !== {8'h34, 1'b1} || obs !== expected()) begin
            n_fail++;
            $display("FAIL resume_tick: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_load_clamp();
        step(1, 8'hAF, 0, 0, 0);
        n_checks++;
        if ({tens, ones} !== 8'h99 || obs !== expected()) begin
            n_fail++;
            $display("FAIL load_clamp: got %h required %h", obs, expected());
        end
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        n_checks++;
        if ({tens, ones, running, time_up, expire_pulse} !== {8'h00, 3'b011} || obs !== expected()) begin
            n_fail++;
            $display("FAIL start_at_zero: got %h required %h", obs, expected());
        end
        step(0, 8'h00, 1, 0, 0);
        n_checks++;
        if (expire_pulse !== 1'b0 || obs !== expected()) begin
            n_fail++;
            $display("FAIL single_pulse: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_async_reset();
        step(1, 8'h17, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        #1 reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs !== {4'd6, 4'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL async_reset: got %h required %h", obs, {4'd6, 4'd0, 4'b0000});
        end
        #1 reset = 1'b0;
        step(0, 8'h00, 0, 0, 1);
        n_checks++;
        if (obs !== {4'd6, 4'd0, 4'b0000} || obs !== expected()) begin
            n_fail++;
            $display("FAIL tick_after_reset: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_warn();
        bit want;
        step(1, 8'h11, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        for (int v = 10; v >= 0; v--) begin
            step(0, 8'h00, 0, 0, 1);
`ifdef TIMER_WARN_EN
            want = (v >= 1 && v <= 9);
`else
            want = 1'b0;
`endif
            n_checks++;
            if (warn !== want || obs !== expected()) begin
                n_fail++;
                $display("FAIL warn_at_%0d: got %h required warn %0b vec %h", v, obs, want, expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 0);
            n_checks++;
            if (obs !== expected()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i, obs, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_expire();
        test_pause();
        test_load_clamp();
        test_async_reset();
        test_warn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
